// File: rtl/glb_stream_port.sv
// glb_stream_port: host valid/ready streaming port into the four-bank global buffer.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_dir/cmd_glb                  0 = write GLB, 1 = read GLB; target GLB select
//   cmd_base_addr/cmd_num_words      first word address, word count (0..2^ADDR_WIDTH)
//   s_data/s_valid/s_ready           write stream into the GLB
//   m_data/m_valid/m_last/m_ready    read stream out of the GLB
//   mem_glb/mem_bank/mem_row         GLB, bank (addr[1:0]) and row (addr>>2) of the access
//   mem_we/mem_re/mem_wdata          access strobes and write data
//   mem_rdata                        read data, one cycle after mem_re
//   busy/done                        transfer in progress, end-of-transfer pulse
module glb_stream_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [1:0]            cmd_glb,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [ADDR_WIDTH:0]   cmd_num_words,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [1:0]            mem_glb,
    output logic [1:0]            mem_bank,
    output logic [ADDR_WIDTH-3:0] mem_row,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state, state_next;
    logic [1:0]            glb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining, pop_left;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0]            fifo_count, used;
    logic                  rd_ptr, wr_ptr, inflight;
    logic                  accept, wr_fire, pop;

    assign accept    = cmd_valid & cmd_ready;
    assign wr_fire   = s_valid & s_ready;
    assign m_valid   = fifo_count != 2'd0;
    assign pop       = m_valid & m_ready;
    assign m_data    = fifo[rd_ptr];
    assign m_last    = m_valid && pop_left == CNT_ONE;
    assign mem_glb   = glb;
    assign mem_bank  = addr[1:0];
    assign mem_row   = addr[ADDR_WIDTH-1:2];
    assign mem_wdata = s_data;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cmd_num_words == '0 ? DONE : cmd_dir ? READ : WRITE;
            WRITE:   if (wr_fire && remaining == CNT_ONE) state_next = DONE;
            READ:    if (mem_re && remaining == CNT_ONE) state_next = DRAIN;
            DRAIN:   if (fifo_count == 2'd0 && !inflight) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Credit counts the slot freed by a same-cycle pop so a continuously
    // ready sink sees one word per cycle; FIFO + in-flight never exceeds 2.
    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        done      = state == DONE;
        s_ready   = state == WRITE;
        mem_we    = s_ready & s_valid;
        used      = fifo_count + {1'b0, inflight} - {1'b0, pop};
        mem_re    = state == READ && remaining != '0 && used < 2'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glb        <= '0;
            addr       <= '0;
            remaining  <= '0;
            pop_left   <= '0;
            inflight   <= 1'b0;
            fifo_count <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
        end else begin
            inflight   <= mem_re;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
            if (accept) begin
                glb       <= cmd_glb;
                addr      <= cmd_base_addr;
                remaining <= cmd_num_words;
                pop_left  <= cmd_num_words;
            end else if (mem_we || mem_re) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - CNT_ONE;
            end
            if (inflight) begin
                fifo[wr_ptr] <= mem_rdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                pop_left <= pop_left - CNT_ONE;
            end
        end
    end
endmodule
